dma_bus_arbiter: RTL

- CPU-side counterpart of the DMA write engine: the responder to its bus request.
- On a device-ready interrupt it issues the one-cycle DMA command, then services the DMA bus request with a bus grant once the CPU is off the memory bus.
- It stalls the CPU for the duration of the grant, then reports completion to the CPU interrupt logic.
- Sits between the CPU datapath/memory port and the DMA engine.

---
 rtl/dma_pkg.sv | 18 +
 rtl/dma_grant_watchdog.sv | 46 ++++
 rtl/dma_bus_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/dma_pkg.sv
// Shared definitions for the CPU-side DMA bus arbiter, its DMA write engine and the bench.
package dma_pkg;

  localparam int          WORD_SIZE   = 16;
  localparam logic [15:0] DMA_ADDRESS = 16'h01F4;
  localparam logic [15:0] DMA_LENGTH  = 16'd12;

  typedef enum logic [2:0] {
    IDLE,
    DELAY,
    CMD,
    WAIT_BR,
    WAIT_IDLE,
    GRANT,
    DONE
  } dma_state_e;

endpackage

// File: rtl/dma_grant_watchdog.sv
// Grant-cycle counter: loads 1 on grant entry, counts while granted, flags the limit
// and captures the final count for reporting.
module dma_grant_watchdog #(
  parameter int           W     = 16,
  parameter logic [W-1:0] LIMIT = 16'd64
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic         en,
  input  logic         capture,
  output logic         tc,
  output logic [W-1:0] captured
);

  logic [W-1:0] count_q, count_d;
  logic [W-1:0] captured_q, captured_d;

  // The entry cycle is itself a grant cycle, so the count starts at one.
  always_comb begin
    count_d    = count_q;
    captured_d = captured_q;
    if (load) begin
      count_d = {{(W-1){1'b0}}, 1'b1};
    end else if (en) begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end
    if (capture) begin
      captured_d = count_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q    <= '0;
      captured_q <= '0;
    end else begin
      count_q    <= count_d;
      captured_q <= captured_d;
    end
  end

  assign tc       = (count_q == LIMIT);
  assign captured = captured_q;

endmodule

// File: rtl/dma_bus_arbiter.sv
// CPU-side responder to the DMA write engine: issues cmd on a device interrupt,
// grants the bus once the CPU is idle, stalls the CPU meanwhile and reports completion.
module dma_bus_arbiter #(
  parameter int                   WORD_SIZE = dma_pkg::WORD_SIZE,
  parameter logic [WORD_SIZE-1:0] GRANT_MAX = 16'd64,
  parameter int                   CMD_DELAY = 2
) (
  input  logic                 CLK,
  input  logic                 reset_n,
  input  logic                 dev_irq,
  input  logic                 BR,
  input  logic                 cpu_mem_busy,
  output logic                 cmd,
  output logic                 BG,
  output logic                 cpu_stall,
  output logic                 dma_done,
  output logic                 dma_error,
  output logic [WORD_SIZE-1:0] grant_cycles,
  output dma_pkg::dma_state_e  dbg_state
);

  import dma_pkg::*;

  dma_state_e state_q, state_d;
  logic [7:0] dly_q, dly_d;
  logic       pending_q, pending_d;
  logic       err_q, err_d;
  logic       cmd_q, cmd_d;
  logic       bg_q, bg_d;
  logic       stall_q, stall_d;
  logic       done_q, done_d;
  logic       wd_tc;

  always_comb begin
    state_d   = state_q;
    dly_d     = dly_q;
    pending_d = pending_q;
    err_d     = err_q;

    // Single pending slot: an interrupt arriving mid-transfer is remembered once.
    if (dev_irq && (state_q != IDLE)) begin
      pending_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (dev_irq || pending_q) begin
          pending_d = 1'b0;
          if (CMD_DELAY == 0) begin
            state_d = CMD;
          end else begin
            state_d = DELAY;
            dly_d   = 8'(CMD_DELAY);
          end
        end
      end
      DELAY: begin
        dly_d = dly_q - 8'd1;
        if (dly_q <= 8'd1) begin
          state_d = CMD;
        end
      end
      CMD:     state_d = WAIT_BR;
      WAIT_BR: begin
        if (BR) begin
          state_d = cpu_mem_busy ? WAIT_IDLE : GRANT;
        end
      end
      WAIT_IDLE: begin
        if (!cpu_mem_busy) begin
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!BR) begin
          state_d = DONE;
        end else if (wd_tc) begin
          state_d = DONE;
          err_d   = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so each one is a plain flop.
    cmd_d   = (state_d == CMD);
    bg_d    = (state_d == GRANT);
    stall_d = (state_d == WAIT_IDLE) || (state_d == GRANT);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      dly_q     <= '0;
      pending_q <= 1'b0;
      err_q     <= 1'b0;
      cmd_q     <= 1'b0;
      bg_q      <= 1'b0;
      stall_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dly_q     <= dly_d;
      pending_q <= pending_d;
      err_q     <= err_d;
      cmd_q     <= cmd_d;
      bg_q      <= bg_d;
      stall_q   <= stall_d;
      done_q    <= done_d;
    end
  end

  dma_grant_watchdog #(
    .W     (WORD_SIZE),
    .LIMIT (GRANT_MAX)
  ) u_watchdog (
    .clk      (CLK),
    .reset_n  (reset_n),
    .load     ((state_d == GRANT) && (state_q != GRANT)),
    .en       (state_q == GRANT),
    .capture  ((state_q == GRANT) && (state_d == DONE)),
    .tc       (wd_tc),
    .captured (grant_cycles)
  );

  assign cmd       = cmd_q;
  assign BG        = bg_q;
  assign cpu_stall = stall_q;
  assign dma_done  = done_q;
  assign dma_error = err_q;
  assign dbg_state = state_q;

endmodule
